// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit scheduler: frame geometry, header
// layout and the FSM state encoding.
package spi_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int HDR_VALID     = 7;
  localparam int HDR_RETRY     = 6;
  localparam int FRAME_BITS    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Header byte: valid flag, retry flag, zeros, requester id (zero when empty).
  function automatic logic [7:0] make_header(input logic carry, input logic retry,
                                             input logic [1:0] id);
    logic [7:0] h;
    h            = '0;
    h[HDR_VALID] = carry;
    h[HDR_RETRY] = retry;
    h[1:0]       = carry ? id : 2'b00;
    return h;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Three-flop synchroniser for an asynchronous SPI pin with level and edge
// strobes taken from the two oldest stages.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  // Resets to all ones so an idle-high SS never produces a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 3'b111;
    else     sync_q <= {sync_q[1:0], din};
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_tx_scheduler.sv
// SPI slave transmit scheduler: each SS frame carries one requester byte as
// {header, payload}, chosen by replay-first then round-robin priority.
module spi_tx_scheduler
  import spi_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SCK,
  input  logic                 SS,
  output logic                 MISO,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 busy,
  output state_e               dbg_state
);

  logic sck_level_unused, sck_rise, sck_fall;
  logic ss_level_unused, ss_rise, ss_fall;

  spi_edge_sync u_sck_sync (
    .clk(clk), .rst(rst), .din(SCK),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_edge_sync u_ss_sync (
    .clk(clk), .rst(rst), .din(SS),
    .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
  );

  state_e      state;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [1:0]  rr_ptr;
  logic        replay_valid;
  logic [1:0]  replay_id;
  logic [7:0]  replay_data;
  logic        cur_carry;
  logic [1:0]  cur_id;
  logic [7:0]  cur_data;

  // Round-robin search: the lowest valid index at or above rr_ptr wins,
  // otherwise wrap to the lowest valid index overall.
  logic       hit_hi, hit_lo, rr_hit;
  logic [1:0] sel_hi, sel_lo, rr_sel, rr_next;
  logic [7:0] data_hi, data_lo, rr_data;

  always_comb begin
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    sel_hi  = '0;
    sel_lo  = '0;
    data_hi = '0;
    data_lo = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        hit_lo  = 1'b1;
        sel_lo  = 2'(i);
        data_lo = req_data[8*i +: 8];
        if (i >= int'(rr_ptr)) begin
          hit_hi  = 1'b1;
          sel_hi  = 2'(i);
          data_hi = req_data[8*i +: 8];
        end
      end
    end
    rr_hit  = hit_hi | hit_lo;
    rr_sel  = hit_hi ? sel_hi : sel_lo;
    rr_data = hit_hi ? data_hi : data_lo;
    rr_next = (rr_sel == 2'(N_REQ - 1)) ? 2'd0 : rr_sel + 2'd1;
  end

  // Handshake: a requester's byte is taken in the cycle where req_valid[i] and
  // req_ready[i] are both high; ready is a single-cycle one-hot pulse issued
  // only in GRANT, never for a replay, and requesters may not retract data
  // while valid is high.
  assign req_ready = (state == ST_GRANT && !replay_valid && rr_hit)
                     ? (N_REQ'(1) << rr_sel) : '0;

  logic last_rise;
  assign last_rise = sck_rise && (bit_cnt == 5'(FRAME_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      rr_ptr       <= '0;
      replay_valid <= 1'b0;
      replay_id    <= '0;
      replay_data  <= '0;
      cur_carry    <= 1'b0;
      cur_id       <= '0;
      cur_data     <= '0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ss_fall) state <= ST_GRANT;
        end
        ST_GRANT: begin
          bit_cnt <= '0;
          state   <= ST_SHIFT;
          if (replay_valid) begin
            cur_carry <= 1'b1;
            cur_id    <= replay_id;
            cur_data  <= replay_data;
            shift_reg <= {make_header(1'b1, 1'b1, replay_id), replay_data};
          end else if (rr_hit) begin
            cur_carry <= 1'b1;
            cur_id    <= rr_sel;
            cur_data  <= rr_data;
            shift_reg <= {make_header(1'b1, 1'b0, rr_sel), rr_data};
            rr_ptr    <= rr_next;
          end else begin
            cur_carry <= 1'b0;
            cur_id    <= '0;
            cur_data  <= '0;
            shift_reg <= '0;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) bit_cnt <= bit_cnt + 5'd1;
          if (sck_fall) shift_reg <= {shift_reg[14:0], 1'b0};
          // A completing 16th rise outranks a coincident SS rise.
          if (last_rise) begin
            frame_done   <= 1'b1;
            replay_valid <= 1'b0;
            state        <= ss_rise ? ST_IDLE : ST_DRAIN;
          end else if (ss_rise) begin
            frame_abort <= 1'b1;
            state       <= ST_IDLE;
            if (cur_carry) begin
              replay_valid <= 1'b1;
              replay_id    <= cur_id;
              replay_data  <= cur_data;
            end
          end
        end
        ST_DRAIN: begin
          if (ss_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign MISO      = (state == ST_IDLE) ? 1'b1 : shift_reg[15];
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler: an SPI master driver, a frame-level
// behavioural model with an expected-word queue, and a per-cycle compare process.
module tb_spi_tx_scheduler;
  import spi_pkg::*;

  localparam int N = 4;
  localparam int H = 6;  // SCK half period in clk cycles

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sck = 1'b0;
  logic           ss  = 1'b1;
  logic           miso;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           frame_done, frame_abort, busy;
  state_e         dbg_state;

  spi_tx_scheduler #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .SCK(sck), .SS(ss), .MISO(miso),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .frame_done(frame_done), .frame_abort(frame_abort), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / model state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [N-1:0] exp_mask = '0;
  int          grant_cyc = -1;
  bit          idle_ok = 1'b0;
  int          done_cnt = 0;
  int          abort_cnt = 0;

  int          m_rr = 0;
  bit          m_rep_v = 1'b0;
  int          m_rep_id = 0;
  logic [7:0]  m_rep_data = '0;
  bit          exp_carry;
  int          exp_id;
  logic [7:0]  exp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level rules: replay first, else round robin from m_rr, else empty.
  task automatic predict();
    bit found;
    found = 1'b0;
    if (m_rep_v) begin
      exp_carry = 1'b1;
      exp_id    = m_rep_id;
      exp_data  = m_rep_data;
      exp_mask  = '0;
      exp_q.push_back({8'hC0 | 8'(exp_id), exp_data});
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!found && req_valid[i]) begin
          found  = 1'b1;
          exp_id = i;
        end
      end
      if (found) begin
        exp_carry = 1'b1;
        exp_data  = req_data[8*exp_id +: 8];
        exp_mask  = N'(1) << exp_id;
        m_rr      = (exp_id + 1) % N;
        exp_q.push_back({8'h80 | 8'(exp_id), exp_data});
      end else begin
        exp_carry = 1'b0;
        exp_id    = 0;
        exp_data  = '0;
        exp_mask  = '0;
        exp_q.push_back(16'h0000);
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
    check("req_ready", 32'(req_ready), (cyc == grant_cyc) ? 32'(exp_mask) : 32'd0);
    if (idle_ok) begin
      check("idle_miso", 32'(miso), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
    end
  end

  // ---------------- driver ----------------
  // mode 0: SS rises after n bits; mode 1: SS rises with the n-th SCK rise;
  // mode 2: rst pulses after n bits.
  task automatic run_frame(input int n, input int mode,
                           input logic [15:0] pin_word, input logic [N-1:0] pin_mask);
    logic [15:0]  rx, want, keep;
    logic [N-1:0] seen;
    bit           exp_done, exp_abort;
    @(negedge clk);
    idle_ok   = 1'b0;
    done_cnt  = 0;
    abort_cnt = 0;
    predict();
    grant_cyc = cyc + 3;
    ss        = 1'b0;
    repeat (3) @(negedge clk);
    seen = req_ready;
    @(negedge clk);
    req_valid &= ~seen;
    repeat (H) @(negedge clk);
    rx = '0;
    for (int b = 0; b < n; b++) begin
      rx[15-b] = miso;
      sck = 1'b1;
      if (mode == 1 && b == n - 1) ss = 1'b1;
      repeat (H) @(negedge clk);
      if (b == 7) check("busy_mid", 32'(busy), 32'd1);
      sck = 1'b0;
      repeat (H) @(negedge clk);
    end
    if (mode == 2) begin
      rst = 1'b1;
      ss  = 1'b1;
      @(negedge clk);
      idle_ok = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
    end else if (mode == 0) begin
      ss = 1'b1;
    end
    repeat (8) @(negedge clk);
    idle_ok = 1'b1;

    keep = ~(16'hFFFF >> n);
    want = exp_q.pop_front();
    check("frame_bits", 32'(rx & keep), 32'(want & keep));
    check("pin_word",   32'(rx & keep), 32'(pin_word & keep));
    check("grant_seen", 32'(seen), 32'(exp_mask));
    check("pin_mask",   32'(seen), 32'(pin_mask));
    exp_done  = (mode == 1) || (mode == 0 && n == 16);
    exp_abort = (mode == 0 && n < 16);
    check("frame_done_cnt",  32'(done_cnt),  exp_done  ? 32'd1 : 32'd0);
    check("frame_abort_cnt", 32'(abort_cnt), exp_abort ? 32'd1 : 32'd0);

    if (mode == 2) begin
      m_rr    = 0;
      m_rep_v = 1'b0;
    end else if (exp_done) begin
      m_rep_v = 1'b0;
    end else if (exp_carry) begin
      m_rep_v    = 1'b1;
      m_rep_id   = exp_id;
      m_rep_data = exp_data;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_miso",  32'(miso),        32'd1);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_ready", 32'(req_ready),   32'd0);
    check("rst_done",  32'(frame_done),  32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    idle_ok = 1'b1;

    // All four requesters: ids served 0,1,2,3.
    req_valid = 4'b1111;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    run_frame(16, 0, 16'h8011, 4'b0001);
    run_frame(16, 0, 16'h8122, 4'b0010);
    run_frame(16, 0, 16'h8233, 4'b0100);
    run_frame(16, 0, 16'h8344, 4'b1000);

    // Single requester 0 with 0xA5.
    req_valid = 4'b0001;
    req_data  = {8'h00, 8'h00, 8'h00, 8'hA5};
    run_frame(16, 0, 16'h80A5, 4'b0001);

    // Empty frame, then rr_ptr still points at 1.
    req_valid = 4'b0000;
    run_frame(16, 0, 16'h0000, 4'b0000);
    req_valid = 4'b1111;
    req_data  = {8'h4D, 8'h3C, 8'h2B, 8'h1A};
    run_frame(16, 0, 16'h812B, 4'b0010);

    // Abort after 5 bits, replay wins over a valid requester 0.
    req_valid = 4'b0101;
    req_data  = {8'h00, 8'h5C, 8'h00, 8'h77};
    run_frame(5,  0, 16'h825C, 4'b0100);
    run_frame(16, 0, 16'hC25C, 4'b0000);
    run_frame(16, 0, 16'h8077, 4'b0001);

    // Reset during a replay frame discards it and rr_ptr.
    req_valid = 4'b0010;
    req_data  = {8'h00, 8'h00, 8'h99, 8'h00};
    run_frame(3, 0, 16'h8199, 4'b0010);
    run_frame(8, 2, 16'hC199, 4'b0000);
    req_valid = 4'b1111;
    req_data  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    run_frame(16, 0, 16'h80A1, 4'b0001);

    // Coincident 16th rise and SS rise completes the replay and clears it.
    run_frame(4,  0, 16'h81B2, 4'b0010);
    run_frame(16, 1, 16'hC1B2, 4'b0000);
    run_frame(16, 0, 16'h82C3, 4'b0100);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_tx_scheduler.md
SPI_TX_SCHEDULER -- requirements
Module: spi_tx_scheduler

Interface
REQ-001 Parameter: N_REQ, default 4, number of FPGA-side requesters (fixed 1..4; id fits 2 bits).
REQ-002 clk  in  1  system clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 SCK  in  1  SPI clock from master, asynchronous to clk.
REQ-005 SS  in  1  SPI slave select from master, active-low, asynchronous to clk.
REQ-006 MISO  out  1  serial data to master, MSB first.
REQ-007 req_valid  in  N_REQ  per-requester byte available.
REQ-008 req_data  in  8*N_REQ  per-requester byte; requester i at bits [8i+7:8i].
REQ-009 req_ready  out  N_REQ  one-hot, one-cycle grant pulse; the byte transfers when valid&ready.
REQ-010 frame_done  out  1  one-cycle pulse after a complete 16-bit frame.
REQ-011 frame_abort  out  1  one-cycle pulse when SS deasserts before 16 bits.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 SCK and SS SHALL each pass a 3-flop synchroniser; edges are detected on stages [2:1]; SS active = ~stage[1].
REQ-014 The master SHALL hold at least 4 clk cycles between SS fall and the first SCK rise, and between SCK edges; the block relies on this.
REQ-015 FSM states: IDLE, GRANT, SHIFT, DRAIN.
REQ-016 IDLE -> GRANT on synced SS falling edge; all other inputs ignored in IDLE.
REQ-017 GRANT (exactly 1 cycle): select source, load 16-bit shift register {header, payload}, clear bit counter, -> SHIFT.
REQ-018 Source priority in GRANT: pending replay first (no req_ready pulse); else round-robin over req_valid starting at pointer rr_ptr; else empty frame.
REQ-019 On a round-robin grant to i, req_ready[i] SHALL pulse in the GRANT cycle, and rr_ptr <= (i+1) mod N_REQ; rr_ptr is unchanged on replay or an empty frame.
REQ-020 Header byte: bit7 = valid (1 if a byte is carried), bit6 = retry (1 if replay), bits5:2 = 0, bits1:0 = requester id; an empty frame sends header 0x00 and payload 0x00.
REQ-021 MISO = shift_reg[15] in GRANT, SHIFT and DRAIN; MISO = 1 in IDLE.
REQ-022 SHIFT: each synced SCK rising edge increments the bit counter (5 bits); each synced SCK falling edge shifts left, filling with 0.
REQ-023 SHIFT -> DRAIN when the 16th rising edge is counted; frame_done pulses on that transition.
REQ-024 DRAIN: SCK edges are ignored and MISO holds; DRAIN -> IDLE on synced SS rising edge.
REQ-025 SHIFT with synced SS rising edge and fewer than 16 rising edges counted -> IDLE; frame_abort pulses.
REQ-026 If the aborted frame carried a byte, its data and id SHALL be stored as the replay entry; a replayed frame sets retry = 1.
REQ-027 Only one replay entry exists; it is cleared when its frame completes (frame_done).
REQ-028 16th SCK rise and SS rise detected in the same cycle: the frame SHALL be treated as complete (frame_done, no abort).
REQ-029 A req_valid asserted in the GRANT cycle itself is eligible for selection.
REQ-030 req_ready SHALL never pulse outside GRANT and SHALL never pulse more than one bit at a time.

Reset
REQ-031 When rst is asserted: state = IDLE, MISO = 1, req_ready = 0, frame_done = 0, frame_abort = 0, busy = 0, rr_ptr = 0, replay cleared, shift register = 0, bit counter = 0, synchronisers = all 1s (SS inactive).
REQ-032 Reset mid-frame SHALL discard the frame and the replay without an abort pulse; the next SS fall after release starts a fresh frame.

Structure
REQ-033 Shared package spi_pkg SHALL hold: N_REQ default, header bit positions (VALID = 7, RETRY = 6), FRAME_BITS = 16, and the FSM state enum.
REQ-034 One sub-module, spi_edge_sync (3-flop synchroniser plus rise/fall/level outputs), SHALL be instantiated twice (SCK, SS).

Verification
REQ-035 req_valid = 0001, data0 = 0xA5; full frame -> req_ready = 0001 for one cycle; MISO bits = 0x80, 0xA5; frame_done = 1 pulse.
REQ-036 All four valid (0x11, 0x22, 0x33, 0x44), 4 frames -> ids 0, 1, 2, 3 in order; headers 0x80, 0x81, 0x82, 0x83.
REQ-037 No requests -> frame reads 0x0000; no req_ready pulse; rr_ptr unchanged.
REQ-038 Requester 2 holds 0x5C; SS rises after 5 bits -> frame_abort pulse; next frame = 0xC2, 0x5C with no req_ready pulse, even while requester 0 is valid.
REQ-039 rst pulsed after 8 bits -> MISO = 1, busy = 0, no pulses; the following frame is round-robin from id 0, with no retry.
REQ-040 16th SCK rise coincident with SS rise -> frame_done = 1, frame_abort = 0, replay empty.
